// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } sa_state_t;

   // Counter must reach WIDTH after the last shift, hence clog2(WIDTH+1).
   function automatic int sa_cnt_w(input int width);
      return (width < 1) ? 1 : $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full adder built from two half-adder stages and an OR of their carries.
module serial_adder_fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic ha1_s;
   logic ha1_c;
   logic ha2_c;

   assign ha1_s = a ^ b;
   assign ha1_c = a & b;
   assign s     = ha1_s ^ cin;
   assign ha2_c = ha1_s & cin;
   assign cout  = ha1_c | ha2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = sa_cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   sa_state_t        state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fa_s;
   logic             fa_cout;
   logic [WIDTH-1:0] acc_shift;
   logic [WIDTH-1:0] b_load;
   logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
   // Two's-complement subtract: invert B and inject a carry of one.
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub;
`else
   assign b_load     = b;
   assign carry_load = 1'b0;
`endif

   serial_adder_fa u_fa (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   generate
      if (WIDTH == 1) begin : g_acc_w1
         assign acc_shift = fa_s;
      end else begin : g_acc_wn
         assign acc_shift = {fa_s, acc_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = SHIFT;
               a_sr_d  = a;
               b_sr_d  = b_load;
               carry_d = carry_load;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            a_sr_d  = a_sr_q >> 1;
            b_sr_d  = b_sr_q >> 1;
            carry_d = fa_cout;
            acc_d   = acc_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            // sum is only written on the final bit so it never shows partial results.
            if (cnt_q == LAST_CNT) begin
               state_d = DONE;
               sum_d   = acc_shift;
               cout_d  = fa_cout;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SHIFT);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: countdown/arithmetic model plus directed vectors.
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   int checks;
   int failures;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: an accepted operation finishes WIDTH edges later with the plain arithmetic result.
   int             m_rem;
   logic           m_done;
   logic [WIDTH:0] m_res;
   logic [WIDTH-1:0] m_sum;
   logic           m_cout;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem  <= 0;
         m_done <= 1'b0;
         m_res  <= '0;
         m_sum  <= '0;
         m_cout <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_rem != 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_sum  <= m_res[WIDTH-1:0];
               m_cout <= m_res[WIDTH];
               m_done <= 1'b1;
            end
         end else if (start) begin
            m_rem <= WIDTH;
`ifdef SERIAL_ADDER_SUB_EN
            if (sub)
               m_res <= {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            else
               m_res <= {1'b0, a} + {1'b0, b};
`else
            m_res <= {1'b0, a} + {1'b0, b};
`endif
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Every cycle compare the DUT outputs against the model.
   always @(negedge clk) begin
      checkOutput("cyc_busy", 32'(busy), 32'(m_rem != 0));
      checkOutput("cyc_done", 32'(done), 32'(m_done));
      checkOutput("cyc_sum",  32'(sum),  32'(m_sum));
      checkOutput("cyc_cout", 32'(cout), 32'(m_cout));
   end

   task automatic applyStimulus(input logic s, input logic sb,
                                input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      @(posedge clk);
      #1;
      start = s;
      sub   = sb;
      a     = av;
      b     = bv;
   endtask

   // Waits (bounded) at negedges for done; returns number of busy cycles seen.
   task automatic waitDone(input string name, output int busy_cycles);
      bit seen;
      seen = 0;
      busy_cycles = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (busy) busy_cycles++;
         if (done) seen = 1;
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_timeout actual=no_done expected=done", name);
      end
   endtask

   task automatic runOp(input string name, input logic sb,
                        input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
      int bc;
      applyStimulus(1'b1, sb, av, bv);
      applyStimulus(1'b0, 1'b0, av, bv);
      waitDone(name, bc);
      checkOutput({name, "_busy_cycles"}, 32'(bc), 32'(WIDTH));
      checkOutput({name, "_sum"}, 32'(sum), 32'(exp_sum));
      checkOutput({name, "_cout"}, 32'(cout), 32'(exp_cout));
   endtask

   initial begin
      int bc;
      int done_count;
      checks   = 0;
      failures = 0;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_sum",  32'(sum),  32'd0);
      checkOutput("reset_cout", 32'(cout), 32'd0);
      rst_n = 1'b1;

      runOp("add_0f_01", 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0);
      runOp("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1);
      runOp("add_ff_ff", 1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1);
      runOp("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0);

      // Start while busy must be ignored.
      applyStimulus(1'b1, 1'b0, 8'h01, 8'h02);
      applyStimulus(1'b0, 1'b0, 8'h01, 8'h02);
      applyStimulus(1'b0, 1'b0, 8'h01, 8'h02);
      applyStimulus(1'b1, 1'b0, 8'hAA, 8'h02);
      applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
      waitDone("ignore", bc);
      checkOutput("ignore_sum", 32'(sum), 32'h03);
      checkOutput("ignore_cout", 32'(cout), 32'd0);

      // Back-to-back: start asserted in the DONE cycle.
      #1;
      start = 1'b1;
      a     = 8'h10;
      b     = 8'h20;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("b2b_busy_resumes", 32'(busy), 32'd1);
      checkOutput("b2b_done_cleared", 32'(done), 32'd0);
      checkOutput("b2b_sum_held", 32'(sum), 32'h03);
      waitDone("b2b", bc);
      checkOutput("b2b_busy_cycles", 32'(bc), 32'(WIDTH));
      checkOutput("b2b_sum", 32'(sum), 32'h30);

      // Reset mid-operation aborts and clears the held result.
      applyStimulus(1'b1, 1'b0, 8'h33, 8'h44);
      applyStimulus(1'b0, 1'b0, 8'h33, 8'h44);
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("abort_sum",  32'(sum),  32'd0);
      checkOutput("abort_cout", 32'(cout), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      done_count = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) done_count++;
      end
      checkOutput("abort_no_done", 32'(done_count), 32'd0);

`ifdef SERIAL_ADDER_SUB_EN
      runOp("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0);
      runOp("sub_07_05", 1'b1, 8'h07, 8'h05, 8'h02, 1'b1);
`endif

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
